// File: rtl/nor_output_monitor.sv
// Quad NOR output monitor: synchronizes and debounces four gate outputs, then
// records each accepted level change as a timestamped event in a 4-deep FIFO.
module nor_output_monitor #(
    parameter int unsigned STABLE = 3,
    parameter logic [3:0]  INIT   = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  y,
    output logic [3:0]  stable,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [15:0] ev_data,
    output logic        ovf,
    input  logic        clr_ovf
);

    localparam logic [3:0] LAST = 4'(STABLE - 1);

    logic [3:0]  s1_reg, s2_reg, stable_reg;
    logic [3:0]  flip;
    logic [3:0]  cnt_reg [4];
    logic [7:0]  ts_reg;
    logic        pend_valid_reg;
    logic [15:0] pend_data_reg;
    logic [15:0] mem_reg [4];
    logic [1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [2:0]  count_reg;
    logic        ovf_reg;

    logic push, pop, full, accept, drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg <= INIT;
            s2_reg <= INIT;
        end else begin
            s1_reg <= y;
            s2_reg <= s1_reg;
        end
    end

    // Per-channel debounce: the counter tracks how long s2 has disagreed with stable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic differs;
            assign differs  = (s2_reg[gi] != stable_reg[gi]);
            assign flip[gi] = differs && (cnt_reg[gi] == LAST);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    cnt_reg[gi] <= 4'd0;
                else if (!differs || flip[gi])
                    cnt_reg[gi] <= 4'd0;
                else
                    cnt_reg[gi] <= cnt_reg[gi] + 4'd1;
            end
        end
    endgenerate

    // The event is staged one cycle so it can be stamped with the pre-increment time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_reg     <= INIT;
            ts_reg         <= 8'd0;
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= 16'd0;
        end else begin
            stable_reg     <= stable_reg ^ flip;
            ts_reg         <= ts_reg + 8'd1;
            pend_valid_reg <= (flip != 4'd0);
            pend_data_reg  <= {flip, stable_reg ^ flip, ts_reg};
        end
    end

    assign pop    = (count_reg != 3'd0) && ev_ready;
    assign push   = pend_valid_reg;
    assign full   = (count_reg == 3'd4);
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (accept)
            mem_reg[wr_ptr_reg] <= pend_data_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
            ovf_reg    <= 1'b0;
        end else begin
            if (accept)
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_reg + {2'd0, accept} - {2'd0, pop};
            // A drop on the same edge as clr_ovf keeps the flag set.
            if (drop)
                ovf_reg <= 1'b1;
            else if (clr_ovf)
                ovf_reg <= 1'b0;
        end
    end

    assign stable   = stable_reg;
    assign ev_valid = (count_reg != 3'd0);
    assign ev_data  = ev_valid ? mem_reg[rd_ptr_reg] : 16'd0;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_nor_output_monitor.sv
// Bench for nor_output_monitor: directed scenarios plus random traffic, compared
// every cycle against a queue-based behavioural model of the monitor.
module tb_nor_output_monitor;

    localparam int         STABLE = 3;
    localparam logic [3:0] INIT   = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  y = INIT;
    logic        ev_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [3:0]  stable;
    logic        ev_valid;
    logic [15:0] ev_data;
    logic        ovf;

    int n_vec = 0;
    int n_bad = 0;

    nor_output_monitor #(.STABLE(STABLE), .INIT(INIT)) dut (
        .clk(clk), .rst(rst), .y(y), .stable(stable), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_data(ev_data), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: y samples travel through a two-deep delay line, each channel
    // counts how many consecutive synchronized samples disagree with its accepted level.
    logic [3:0]  m_s1, m_s2, m_stable;
    int          m_run [4];
    int          m_ts;
    bit          m_pend_v;
    logic [15:0] m_pend_d;
    logic [15:0] m_q [$];
    bit          m_ovf;

    function automatic void model_reset();
        m_s1 = INIT;
        m_s2 = INIT;
        m_stable = INIT;
        foreach (m_run[i]) m_run[i] = 0;
        m_ts = 0;
        m_pend_v = 0;
        m_pend_d = 16'd0;
        m_q.delete();
        m_ovf = 0;
    endfunction

    function automatic void model_edge();
        bit         pop;
        bit         drop;
        logic [3:0] mask;
        pop  = (m_q.size() != 0) && ev_ready;
        drop = 0;
        if (pop) void'(m_q.pop_front());
        if (m_pend_v) begin
            if (m_q.size() < 4) m_q.push_back(m_pend_d);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        mask = 4'd0;
        for (int ch = 0; ch < 4; ch++) begin
            if (m_s2[ch] != m_stable[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == STABLE) begin
                    mask[ch] = 1'b1;
                    m_run[ch] = 0;
                end
            end else begin
                m_run[ch] = 0;
            end
        end
        m_stable = m_stable ^ mask;
        m_pend_v = (mask != 4'd0);
        m_pend_d = {mask, m_stable, 8'(m_ts)};
        m_ts = (m_ts + 1) % 256;
        m_s2 = m_s1;
        m_s1 = y;
    endfunction

    task automatic compare_all();
        check("stable", 32'(stable), 32'(m_stable));
        check("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("ev_data", 32'(ev_data), 32'(m_q[0]));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic tick();
        if (rst) model_edge();
        else model_reset();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          prev_ts;
        int          npop;
        model_reset();
        #12;
        check("rst_stable", 32'(stable), 32'(INIT));
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_ev_data", 32'(ev_data), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Basic latency and timestamp
        y = 4'b0001;
        ev_ready = 1'b1;
        hold(5);
        check("lat_stable_e5", 32'(stable), 32'h1);
        check("lat_valid_e5", 32'(ev_valid), 32'd0);
        tick();
        check("lat_valid_e6", 32'(ev_valid), 32'd1);
        check("lat_data_e6", 32'(ev_data), 32'h1104);
        tick();
        check("lat_popped_e7", 32'(ev_valid), 32'd0);

        // Short glitch on channel 2
        y = 4'b0101;
        hold(2);
        y = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch_stable", 32'(stable), 32'h1);
            check("glitch_valid", 32'(ev_valid), 32'd0);
        end

        // Two channels changing together
        y = 4'b0000;
        hold(8);
        ev_ready = 1'b0;
        y = 4'b1010;
        hold(8);
        check("multi_head", 32'(ev_data[15:8]), 32'hAA);
        ev_ready = 1'b1;
        tick();
        check("multi_single", 32'(ev_valid), 32'd0);

        // Overflow with five queued toggles
        ev_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            y[0] = ~y[0];
            hold(8);
        end
        check("ovf_set", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        ev_ready = 1'b1;
        prev_ts = -1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 32'(ev_valid), 32'd1);
            check("drain_ts_order", 32'(int'(ev_data[7:0]) > prev_ts), 32'd1);
            prev_ts = int'(ev_data[7:0]);
            tick();
        end
        check("drain_empty", 32'(ev_valid), 32'd0);

        // Full FIFO with push and pop on the same edge
        ev_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            y[1] = ~y[1];
            hold(8);
        end
        y[1] = ~y[1];
        hold(5);
        ev_ready = 1'b1;
        tick();
        check("full_pushpop_ovf", 32'(ovf), 32'd0);
        npop = 0;
        while (ev_valid && npop < 10) begin
            npop++;
            tick();
        end
        check("full_pushpop_occ", 32'(npop), 32'd4);

        // Asynchronous reset mid-debounce with events queued
        ev_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            y[3] = ~y[3];
            hold(8);
        end
        y[2] = ~y[2];
        hold(3);
        #2 rst = 1'b0;
        #2;
        check("async_valid", 32'(ev_valid), 32'd0);
        check("async_stable", 32'(stable), 32'(INIT));
        check("async_data", 32'(ev_data), 32'd0);
        check("async_ovf", 32'(ovf), 32'd0);
        hold(2);
        rst = 1'b1;
        hold(10);
        ev_ready = 1'b1;
        hold(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) y = 4'($urandom);
            ev_ready = ($urandom_range(3) != 0);
            clr_ovf  = ($urandom_range(15) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
